// File: rtl/ssd_display_arbiter_if.sv
// Purpose: bundles the requester-facing and board-facing signals of the
//          seven-segment display arbiter.
// Signals:
//   req[2:0]   request per requester (bit i = requester i)
//   msg0..2    16-bit glyph messages, [3:0] rightmost .. [15:12] leftmost
//   grant[2:0] one-hot current owner, 000 when idle
//   an[3:0]    anode enables, active-low
//   seg[6:0]   cathodes, active-low, seg[6]=g .. seg[0]=a
// Modports: master = requesters/board side, slave = arbiter side.
interface ssd_display_arbiter_if;
   logic [2:0]  req;
   logic [15:0] msg0;
   logic [15:0] msg1;
   logic [15:0] msg2;
   logic [2:0]  grant;
   logic [3:0]  an;
   logic [6:0]  seg;

   modport master (
      output req, msg0, msg1, msg2,
      input  grant, an, seg
   );

   modport slave (
      input  req, msg0, msg1, msg2,
      output grant, an, seg
   );
endinterface

// File: rtl/ssd_display_arbiter.sv
// Purpose: shares a 4-digit seven-segment display between three requesters.
//          Round-robin ownership with a minimum dwell time, time-multiplexed
//          anode scanning and glyph decode of the owner's live message.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  ssd_display_arbiter_if.slave (req, msg0..2 in; grant, an, seg out)
// Parameters:
//   DIG_BITS      digit advances every 2^DIG_BITS cycles
//   DWELL_CYCLES  minimum ownership time in cycles (>= 2, fits 27 bits)
module ssd_display_arbiter #(
   parameter int unsigned DIG_BITS     = 17,
   parameter int unsigned DWELL_CYCLES = 100000000
) (
   input  logic                 clk,
   input  logic                 rst,
   ssd_display_arbiter_if.slave bus
);

   localparam int unsigned SCAN_W  = DIG_BITS + 2;
   localparam int unsigned DWELL_W = 27;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OWN  = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [2:0]         grant_q, grant_d;
   logic [1:0]         last_q,  last_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [SCAN_W-1:0]  scan_q,  scan_d;
   logic [3:0]         an_q,    an_d;
   logic [6:0]         seg_q,   seg_d;

   logic [2:0]  pick_any;
   logic [2:0]  pick_other;
   logic [1:0]  digit;
   logic [15:0] owner_msg;
   logic [3:0]  nibble;

   // First requester after ptr, searching cyclically; returns {valid, index}.
   function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] r);
      logic [1:0] c0, c1, c2;
      case (ptr)
         2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
         2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
         default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
      endcase
      if (r[c0])      return {1'b1, c0};
      else if (r[c1]) return {1'b1, c1};
      else if (r[c2]) return {1'b1, c2};
      else            return 3'b000;
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      case (idx)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   // Glyph code to active-low cathodes {g,f,e,d,c,b,a}.
   function automatic logic [6:0] decode(input logic [3:0] code);
      case (code)
         4'h0:    return 7'b1000000;
         4'h1:    return 7'b1111001;
         4'h2:    return 7'b0100100;
         4'h3:    return 7'b0110000;
         4'h4:    return 7'b0011001;
         4'h5:    return 7'b0010010;
         4'h6:    return 7'b0000010;
         4'h7:    return 7'b1111000;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0010000;
         4'hA:    return 7'b0001110;
         4'hB:    return 7'b0000011;
         4'hC:    return 7'b0111111;
         4'hD:    return 7'b1000001;
         4'hE:    return 7'b1000000;
         default: return 7'b1111111;
      endcase
   endfunction

   // State, arbitration and display registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= 3'b000;
         last_q  <= 2'd2;
         dwell_q <= '0;
         scan_q  <= '0;
         an_q    <= 4'b1111;
         seg_q   <= 7'b1111111;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         dwell_q <= dwell_d;
         scan_q  <= scan_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   // Next-state logic: arbitration FSM plus anode/cathode selection.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      dwell_d    = dwell_q;
      scan_d     = scan_q + SCAN_W'(1);
      an_d       = 4'b1111;
      seg_d      = 7'b1111111;
      owner_msg  = 16'h0000;
      nibble     = 4'h0;
      digit      = scan_q[SCAN_W-1 -: 2];
      // In OWN last_q is the current owner, so both searches start after it.
      pick_any   = rr_pick(last_q, bus.req);
      pick_other = rr_pick(last_q, bus.req & ~onehot(last_q));

      case (state_q)
         ST_IDLE: begin
            grant_d = 3'b000;
            dwell_d = '0;
            if (pick_any[2]) begin
               state_d = ST_OWN;
               grant_d = onehot(pick_any[1:0]);
               last_d  = pick_any[1:0];
            end
         end
         ST_OWN: begin
            dwell_d = (dwell_q == DWELL_LAST) ? dwell_q : dwell_q + DWELL_W'(1);
            if (!bus.req[last_q]) begin
               // Release wins over dwell expiry.
               dwell_d = '0;
               if (pick_other[2]) begin
                  grant_d = onehot(pick_other[1:0]);
                  last_d  = pick_other[1:0];
               end else begin
                  state_d = ST_IDLE;
                  grant_d = 3'b000;
               end
            end else if (dwell_q == DWELL_LAST) begin
               // Expiry: hand over if anyone else waits, else restart dwell.
               dwell_d = '0;
               if (pick_other[2]) begin
                  grant_d = onehot(pick_other[1:0]);
                  last_d  = pick_other[1:0];
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 3'b000;
            dwell_d = '0;
         end
      endcase

      // Live message of the owner; an and seg come from the same digit index.
      if (state_q == ST_OWN) begin
         case (last_q)
            2'd0:    owner_msg = bus.msg0;
            2'd1:    owner_msg = bus.msg1;
            default: owner_msg = bus.msg2;
         endcase
         case (digit)
            2'd0:    nibble = owner_msg[3:0];
            2'd1:    nibble = owner_msg[7:4];
            2'd2:    nibble = owner_msg[11:8];
            default: nibble = owner_msg[15:12];
         endcase
         an_d  = ~(4'b0001 << digit);
         seg_d = decode(nibble);
      end
   end

   assign bus.grant = grant_q;
   assign bus.an    = an_q;
   assign bus.seg   = seg_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
module tb_ssd_display_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic found;

   logic [3:0] exp_an  [4];
   logic [6:0] exp_seg [4];

   ssd_display_arbiter_if bus_if ();

   ssd_display_arbiter #(
      .DIG_BITS     (2),
      .DWELL_CYCLES (20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_an[0] = 4'b1110; exp_seg[0] = 7'b1000001;  // 'U'
      exp_an[1] = 4'b1101; exp_seg[1] = 7'b1000000;  // 'O'
      exp_an[2] = 4'b1011; exp_seg[2] = 7'b0000011;  // 'b'
      exp_an[3] = 4'b0111; exp_seg[3] = 7'b0001110;  // 'F'

      rst = 1'b1;
      bus_if.req  = 3'b000;
      bus_if.msg0 = 16'hABED;
      bus_if.msg1 = 16'h0123;
      bus_if.msg2 = 16'h4567;

      // Reset state
      step(2);
      check("rst_grant", 16'(bus_if.grant), 16'h0);
      check("rst_an",    16'(bus_if.an),    16'hF);
      check("rst_seg",   16'(bus_if.seg),   16'h7F);
      rst = 1'b0;
      step(3);
      check("idle_grant", 16'(bus_if.grant), 16'h0);
      check("idle_an",    16'(bus_if.an),    16'hF);
      check("idle_seg",   16'(bus_if.seg),   16'h7F);

      // Single requester 0, pointer starts at 2 so requester 0 wins
      bus_if.req = 3'b001;
      step(1);
      check("own0_grant", 16'(bus_if.grant), 16'h1);

      // Align to the start of digit 0 (leaving digit 3)
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1);
         if (bus_if.an === 4'b0111) found = 1'b1;
      end
      check("sync_d3", 16'(found), 16'h1);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         step(1);
         if (bus_if.an === 4'b1110) found = 1'b1;
      end
      check("sync_d0", 16'(found), 16'h1);

      // Four cycles per digit, wraps back to digit 0
      for (int i = 0; i < 17; i++) begin
         check("scan_an",  16'(bus_if.an),  16'(exp_an[(i / 4) % 4]));
         check("scan_seg", 16'(bus_if.seg), 16'(exp_seg[(i / 4) % 4]));
         step(1);
      end

      // Release to idle, display blanks one cycle after grant drops
      bus_if.req = 3'b000;
      step(1);
      check("rel_grant", 16'(bus_if.grant), 16'h0);
      step(1);
      check("rel_an",  16'(bus_if.an),  16'hF);
      check("rel_seg", 16'(bus_if.seg), 16'h7F);

      // Requester 1 alone for 50 cycles: no glitch on dwell restarts
      bus_if.req = 3'b010;
      step(1);
      check("solo1_grant", 16'(bus_if.grant), 16'h2);
      for (int i = 0; i < 50; i++) begin
         step(1);
         check("solo1_hold", 16'(bus_if.grant), 16'h2);
      end

      // Asynchronous reset mid-dwell, between clock edges
      #3 rst = 1'b1;
      #1;
      check("arst_grant", 16'(bus_if.grant), 16'h0);
      check("arst_an",    16'(bus_if.an),    16'hF);
      check("arst_seg",   16'(bus_if.seg),   16'h7F);
      bus_if.req = 3'b000;
      step(1);
      rst = 1'b0;
      step(3);
      check("post_rst_grant", 16'(bus_if.grant), 16'h0);
      check("post_rst_an",    16'(bus_if.an),    16'hF);
      check("post_rst_seg",   16'(bus_if.seg),   16'h7F);

      // All three requesting: 001 -> 010 -> 100 -> 001, 20 cycles apart
      bus_if.req = 3'b111;
      step(1);
      check("rr_first", 16'(bus_if.grant), 16'h1);
      step(19);
      check("rr_hold0", 16'(bus_if.grant), 16'h1);
      step(1);
      check("rr_to1",   16'(bus_if.grant), 16'h2);
      step(19);
      check("rr_hold1", 16'(bus_if.grant), 16'h2);
      step(1);
      check("rr_to2",   16'(bus_if.grant), 16'h4);
      step(19);
      check("rr_hold2", 16'(bus_if.grant), 16'h4);
      step(1);
      check("rr_to0",   16'(bus_if.grant), 16'h1);

      // Owner 0 drops at dwell 5, requester 1 idle: goes to 2
      bus_if.req = 3'b101;
      step(5);
      check("early_hold", 16'(bus_if.grant), 16'h1);
      bus_if.req = 3'b100;
      step(1);
      check("early_rel", 16'(bus_if.grant), 16'h4);
      // Dwell restarted at 0: next handover exactly 20 cycles later
      bus_if.req = 3'b110;
      step(19);
      check("early_dwell_hold", 16'(bus_if.grant), 16'h4);
      step(1);
      check("early_dwell_hand", 16'(bus_if.grant), 16'h2);

      // Owner 1 releases, requester 0 picked up
      bus_if.req = 3'b001;
      step(1);
      check("to0_grant", 16'(bus_if.grant), 16'h1);
      step(19);
      check("exp_hold", 16'(bus_if.grant), 16'h1);
      // req[0] drops on the expiry cycle with req[1] set
      bus_if.req = 3'b010;
      step(1);
      check("exp_rel", 16'(bus_if.grant), 16'h2);

      // Everyone drops: idle, blank one cycle later
      bus_if.req = 3'b000;
      step(1);
      check("end_grant", 16'(bus_if.grant), 16'h0);
      step(1);
      check("end_an",  16'(bus_if.an),  16'hF);
      check("end_seg", 16'(bus_if.seg), 16'h7F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
